// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (load-use, branch, dmem wait-states).
// Optional STALL_CNT_EN macro adds a 32-bit count of cycles with the PC held.
module pipe_hazard_ctrl #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              startin,
    input  logic [4:0]        ID_rs,
    input  logic [4:0]        ID_rt,
    input  logic              EX_mem_read,
    input  logic [4:0]        EX_rt,
    input  logic              EX_branch_taken,
    input  logic              MEM_mem_req,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              pc_write,
    output logic              IF_ID_write,
    output logic              IF_ID_flush,
    output logic              ID_EX_flush,
    output logic              EX_MEM_write,
    output logic              MEM_WB_bubble,
`ifdef STALL_CNT_EN
    output logic              mem_err,
    output logic [31:0]       stall_cycles
`else
    output logic              mem_err
`endif
);
    typedef enum logic [1:0] {RUN = 2'b00, WAIT = 2'b01, ERR_REL = 2'b10} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_wait_cnt, w_next_cnt;
    logic             r_mem_err, w_set_err;
    logic             w_freeze, w_bubble, w_req;
    logic             w_load_use, w_branch, w_stall;

    always_comb begin
        w_next     = r_state;
        w_next_cnt = r_wait_cnt;
        w_set_err  = 1'b0;
        w_freeze   = 1'b0;
        w_bubble   = 1'b0;
        w_req      = 1'b0;
        case (r_state)
            RUN: begin
                w_req = MEM_mem_req;
                if (MEM_mem_req && !dmem_ready) begin
                    w_freeze   = 1'b1;
                    w_next     = WAIT;
                    w_next_cnt = CNT_W'(1);
                end
            end
            WAIT: begin
                w_req = MEM_mem_req;
                if (dmem_ready) begin
                    w_next     = RUN;
                    w_next_cnt = '0;
                end else if (r_wait_cnt < CNT_W'(WAIT_LIMIT)) begin
                    w_freeze   = 1'b1;
                    w_next_cnt = r_wait_cnt + CNT_W'(1);
                end else begin
                    w_freeze   = 1'b1;
                    w_set_err  = 1'b1;
                    w_next     = ERR_REL;
                    w_next_cnt = '0;
                end
            end
            ERR_REL: begin
                // faulted instruction leaves MEM as a NOP; rest of the pipe moves on
                w_bubble   = 1'b1;
                w_next     = RUN;
                w_next_cnt = '0;
            end
            default: begin
                w_next     = RUN;
                w_next_cnt = '0;
            end
        endcase
    end

    // memory freeze outranks branch flush, which outranks load-use stall
    assign w_load_use = EX_mem_read && (EX_rt != 5'd0) && ((EX_rt == ID_rs) || (EX_rt == ID_rt));
    assign w_branch   = !w_freeze && EX_branch_taken;
    assign w_stall    = !w_freeze && !EX_branch_taken && w_load_use;

    assign dmem_req      = startin && w_req;
    assign pc_write      = startin && !w_freeze && !w_stall;
    assign IF_ID_write   = startin && !w_freeze && !w_stall;
    assign IF_ID_flush   = startin && w_branch;
    assign ID_EX_flush   = startin && (w_branch || w_stall);
    assign EX_MEM_write  = startin && !w_freeze;
    assign MEM_WB_bubble = startin && (w_freeze || w_bubble);
    assign mem_err       = r_mem_err;

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_next_cnt;
            r_mem_err  <= r_mem_err || w_set_err;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge startin) begin
        if (!startin)
            r_stall_cycles <= '0;
        else if (!pc_write)
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign stall_cycles = r_stall_cycles;
`endif
endmodule
